tl_lane_sensor: RTL and testbench
=================================

TL_LANE_SENSOR -- requirements
Module: tl_lane_sensor

Interface
REQ-001 Parameter CNT_W, default 4: width of each lane's vehicle-queue counter; maximum count is 2^CNT_W-1.
REQ-002 Parameter DEP_PERIOD, default 2, legal range 1..15: clocks per vehicle departure while a lane is granted.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 arr_a, arr_b, arr_al, arr_bl  input  1 each  one-clock vehicle-arrival pulses for street A straight, B straight, A left, and B left.
REQ-006 La, Lb  input  2 each  light codes from the controller: 2'b00 GREEN, 2'b01 YELLOW, 2'b10 RED, 2'b11 LEFT.
REQ-007 Ta, Tb, Tal, Tbl  output  1 each  traffic-present sensors fed back to the controller, one per lane.
REQ-008 ovf  output  4  sticky overflow flags; bit order {bl, al, b, a}.

Function
REQ-009 Each lane SHALL keep an independent CNT_W-bit queue count (q) and a 4-bit departure timer (tmr).
REQ-010 Grant per lane: a = (La==GREEN); al = (La==LEFT); b = (Lb==GREEN); bl = (Lb==LEFT).
REQ-011 While a lane's grant is false at a rising edge, its tmr SHALL load 0.
REQ-012 While the grant is true, tmr SHALL increment each edge; at the edge where tmr==DEP_PERIOD-1, tmr SHALL load 0 and a departure event SHALL occur.
REQ-013 First departure: on the DEP_PERIOD-th consecutive edge with the grant true; subsequent departures every DEP_PERIOD edges.
REQ-014 The timer SHALL run regardless of q; a departure with q==0 SHALL leave q at 0 (no underflow).
REQ-015 Arrival only: q += 1. Departure only: q -= 1. Arrival and departure on the same edge: q unchanged.
REQ-016 Arrival with q at max and no departure: q SHALL hold at max and the lane's ovf bit SHALL set; the bit stays set until reset.
REQ-017 Ta/Tb/Tal/Tbl SHALL equal (q != 0) of their lane, decoded from the q register with no further register stage.
REQ-018 Sensor latency: an arrival pulse sampled at edge n SHALL be visible on the sensor output immediately after edge n.
REQ-019 A grant change takes effect at the next edge; a partially elapsed timer is discarded when the grant drops.

Reset
REQ-020 reset sampled high SHALL set all q, tmr, and ovf to 0, so Ta=Tb=Tal=Tbl=0 and ovf=4'b0000 after that edge.
REQ-021 reset SHALL take priority over simultaneous arrivals and departures; reset mid-queue discards all counts.
REQ-022 Arrivals SHALL be accepted on the first edge after reset deasserts.

Configuration
REQ-023 Macro TL_YELLOW_DEPART_EN: when defined, the straight-lane grants also include YELLOW (a = La==GREEN or La==YELLOW, likewise b); left-lane grants are unchanged.
REQ-024 Without TL_YELLOW_DEPART_EN, YELLOW is a non-granting code and the timer clears during YELLOW.

Verification
REQ-025 Reset held with arrivals pulsing -> all sensors 0 and ovf 0 throughout.
REQ-026 3 arr_a pulses, La=RED, then La=GREEN for 6 edges (DEP_PERIOD=2) -> q_a goes 3,2,1,0 at edges 2,4,6 after grant start; Ta falls after edge 6.
REQ-027 16 arr_bl pulses with Lb=RED (CNT_W=4) -> q_bl holds at 15, ovf=4'b1000, Tbl=1; after reset, ovf returns to 4'b0000.
REQ-028 Lb=GREEN with q_b=2 and arr_b pulsed on a departure edge -> q_b stays 2 on that edge.
REQ-029 La=YELLOW for 4 edges with q_a=2 -> q_a stays 2 without the macro and reaches 0 with TL_YELLOW_DEPART_EN.
REQ-030 La=LEFT for 1 edge, then RED, then LEFT again, with q_al=1 -> no departure (timer cleared); departure occurs on the 2nd edge of the second LEFT interval.

Source files
------------

// File: rtl/tl_lane_sensor_if.sv
// tl_lane_sensor_if: arrival pulses, light codes and sensor/overflow feedback between controller and lane sensor
interface tl_lane_sensor_if;
    logic       arr_a, arr_b, arr_al, arr_bl;
    logic [1:0] La, Lb;
    logic       Ta, Tb, Tal, Tbl;
    logic [3:0] ovf;
    modport master (output arr_a, arr_b, arr_al, arr_bl, La, Lb, input Ta, Tb, Tal, Tbl, ovf);
    modport slave  (input arr_a, arr_b, arr_al, arr_bl, La, Lb, output Ta, Tb, Tal, Tbl, ovf);
endinterface

// File: rtl/tl_lane_sensor.sv
// tl_lane_sensor: four lane queue counters with timed departures while granted; TL_YELLOW_DEPART_EN lets YELLOW grant straight lanes
module tl_lane_sensor #(
    parameter int CNT_W      = 4,
    parameter int DEP_PERIOD = 2
) (
    input logic            clk,
    input logic            reset,
    tl_lane_sensor_if.slave bus
);
    localparam logic [1:0]       GREEN    = 2'b00;
    localparam logic [1:0]       LEFT     = 2'b11;
    localparam logic [CNT_W-1:0] Q_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] Q_ONE    = CNT_W'(1);
    localparam logic [3:0]       TMR_LAST = 4'(DEP_PERIOD - 1);
    // lane index order matches ovf bits: 0=a, 1=b, 2=al, 3=bl
    logic [3:0]       grant, arr, dep, ovf_d, ovf_q;
    logic [CNT_W-1:0] q_q [4];
    logic [CNT_W-1:0] q_d [4];
    logic [3:0]       tmr_q [4];
    logic [3:0]       tmr_d [4];
    assign arr = {bus.arr_bl, bus.arr_al, bus.arr_b, bus.arr_a};
`ifdef TL_YELLOW_DEPART_EN
    localparam logic [1:0] YELLOW = 2'b01;
    assign grant = {bus.Lb == LEFT, bus.La == LEFT,
                    bus.Lb == GREEN || bus.Lb == YELLOW, bus.La == GREEN || bus.La == YELLOW};
`else
    assign grant = {bus.Lb == LEFT, bus.La == LEFT, bus.Lb == GREEN, bus.La == GREEN};
`endif
    // departure timing and saturating queue arithmetic per lane
    always_comb begin
        dep   = '0;
        ovf_d = ovf_q;
        for (int i = 0; i < 4; i++) begin
            dep[i]   = grant[i] && tmr_q[i] == TMR_LAST;
            tmr_d[i] = (grant[i] && !dep[i]) ? tmr_q[i] + 4'd1 : 4'd0;
            q_d[i]   = q_q[i];
            if (arr[i] && !dep[i]) begin
                if (q_q[i] == Q_MAX) ovf_d[i] = 1'b1;
                else q_d[i] = q_q[i] + Q_ONE;
            end else if (dep[i] && !arr[i] && q_q[i] != '0) begin
                q_d[i] = q_q[i] - Q_ONE;
            end
        end
    end
    // state registers; reset clears queues, timers and sticky overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= '0;
            for (int i = 0; i < 4; i++) begin
                q_q[i]   <= '0;
                tmr_q[i] <= '0;
            end
        end else begin
            ovf_q <= ovf_d;
            for (int i = 0; i < 4; i++) begin
                q_q[i]   <= q_d[i];
                tmr_q[i] <= tmr_d[i];
            end
        end
    end
    assign bus.Ta  = q_q[0] != '0;
    assign bus.Tb  = q_q[1] != '0;
    assign bus.Tal = q_q[2] != '0;
    assign bus.Tbl = q_q[3] != '0;
    assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_tl_lane_sensor.sv
// tb_tl_lane_sensor: directed and random stimulus against a queue-count reference model
module tb_tl_lane_sensor;
    localparam int CNT_W = 4;
    localparam int DP    = 2;
    localparam int QMAX  = (1 << CNT_W) - 1;
    localparam logic [1:0] GREEN = 2'b00, YELLOW = 2'b01, RED = 2'b10, LEFT = 2'b11;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   mq [4];
    int   mrun [4];
    logic [3:0] movf = '0;
    tl_lane_sensor_if bus ();
    tl_lane_sensor #(.CNT_W(CNT_W), .DEP_PERIOD(DP)) dut (.clk(clk), .reset(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [3:0] grants(input logic [1:0] la, input logic [1:0] lb);
`ifdef TL_YELLOW_DEPART_EN
        return {lb == LEFT, la == LEFT, lb == GREEN || lb == YELLOW, la == GREEN || la == YELLOW};
`else
        return {lb == LEFT, la == LEFT, lb == GREEN, la == GREEN};
`endif
    endfunction
    task automatic model_step();
        logic [3:0] a, g;
        logic d;
        a = {bus.arr_bl, bus.arr_al, bus.arr_b, bus.arr_a};
        g = grants(bus.La, bus.Lb);
        if (rst) begin
            movf = '0;
            for (int i = 0; i < 4; i++) begin
                mq[i]   = 0;
                mrun[i] = 0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                mrun[i] = g[i] ? mrun[i] + 1 : 0;
                d = g[i] && (mrun[i] % DP == 0);
                if (a[i] && !d) begin
                    if (mq[i] == QMAX) movf[i] = 1'b1;
                    else mq[i]++;
                end else if (d && !a[i] && mq[i] > 0) begin
                    mq[i]--;
                end
            end
        end
    endtask
    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask
    task automatic tick();
        logic [3:0] et;
        @(posedge clk);
        model_step();
        #1;
        for (int i = 0; i < 4; i++) et[i] = mq[i] != 0;
        check("sensors", {bus.Tbl, bus.Tal, bus.Tb, bus.Ta}, et);
        check("ovf", bus.ovf, movf);
        {bus.arr_bl, bus.arr_al, bus.arr_b, bus.arr_a} = 4'b0000;
    endtask
    task automatic arrive(input logic [3:0] v);
        {bus.arr_bl, bus.arr_al, bus.arr_b, bus.arr_a} = v;
        tick();
    endtask
    initial begin
        {bus.arr_bl, bus.arr_al, bus.arr_b, bus.arr_a} = 4'b0000;
        bus.La = RED;
        bus.Lb = RED;
        repeat (4) arrive(4'b1111);
        rst = 1'b0;
        repeat (3) arrive(4'b0001);
        bus.La = GREEN;
        repeat (6) tick();
        bus.La = RED;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (16) arrive(4'b1000);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (2) arrive(4'b0010);
        bus.Lb = GREEN;
        tick();
        arrive(4'b0010);
        repeat (5) tick();
        bus.Lb = RED;
        repeat (2) arrive(4'b0001);
        bus.La = YELLOW;
        repeat (4) tick();
        bus.La = GREEN;
        repeat (4) tick();
        bus.La = RED;
        arrive(4'b0100);
        bus.La = LEFT;
        tick();
        bus.La = RED;
        tick();
        bus.La = LEFT;
        repeat (2) tick();
        bus.La = RED;
        tick();
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(99) == 0);
            if ($urandom_range(5) == 0) bus.La = 2'($urandom_range(3));
            if ($urandom_range(5) == 0) bus.Lb = 2'($urandom_range(3));
            arrive({$urandom_range(2) == 0, $urandom_range(2) == 0,
                    $urandom_range(2) == 0, $urandom_range(2) == 0});
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
